// File: rtl/cpu_core_mc_if.sv
// cpu_core_mc_if: instruction and data memory req/ack buses of cpu_core_mc
interface cpu_core_mc_if #(
  parameter int DATA_W = 32,
  parameter int PC_W = 16,
  parameter int INSTR_W = 32
);
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic dmem_req;
  logic dmem_we;
  logic [PC_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle CPU sequenced FETCH/DECODE/EXEC/MEM/WB/HALT over req/ack memory ports.
// Define CPU_MUL_EN to add the MULS multiplier; otherwise MULS halts as a reserved opcode.
module cpu_core_mc #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PC_W = 16,
  parameter int INSTR_W = 32
) (
  input  logic clk,
  input  logic rst,
  cpu_core_mc_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic [3:0] flags,
  output logic halted,
  output logic illegal
);
  localparam int RA = REG_ADDR_W;
  localparam int IMM_LO = 5 + 3 * RA;
  localparam int IMM_W = INSTR_W - IMM_LO;
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [4:0] OP_AND = 5'd1, OP_ORR = 5'd2, OP_EOR = 5'd3, OP_MVN = 5'd4,
                         OP_ADDS = 5'd5, OP_ADCS = 5'd6, OP_SUB = 5'd7, OP_SBCS = 5'd8,
                         OP_MULS = 5'd9, OP_LSRS = 5'd10, OP_LSLS = 5'd11, OP_ASR = 5'd12,
                         OP_ROR = 5'd13, OP_UXTB = 5'd14, OP_UXTH = 5'd15, OP_SXTB = 5'd16,
                         OP_SXTH = 5'd17, OP_CMP = 5'd18, OP_NOP = 5'd19, OP_LOADI = 5'd20,
                         OP_STORE = 5'd21, OP_MOV = 5'd22, OP_J = 5'd23, OP_BEQ = 5'd24,
                         OP_HLT = 5'd25;
`ifdef CPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic [2:0] state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] rf [2**RA];
  logic [DATA_W-1:0] a, b, res, bb, alu_r, imm_d;
  logic [PC_W-1:0] maddr, tgt;
  logic wb_we, alu_op, legal, sub_op, cin, add_v, sh_c, upd_c, upd_v, alu_c;
  logic [4:0] op;
  logic [RA-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0] imm;
  logic [SH_W-1:0] sh;
  logic [DATA_W:0] sum;
  logic [3:0] nf;
  assign op = ir[4:0];
  assign rd = ir[5 +: RA];
  assign rs1 = ir[5+RA +: RA];
  assign rs2 = ir[5+2*RA +: RA];
  assign imm = ir[INSTR_W-1:IMM_LO];
  assign imm_d = DATA_W'(imm);
  assign tgt = PC_W'(imm);
  assign sh = b[SH_W-1:0];
  assign alu_op = op >= OP_AND && op <= OP_SXTH && (MUL_EN || op != OP_MULS);
  assign legal = alu_op || (op >= OP_CMP && op <= OP_HLT);
  // One adder serves add and subtract: a - b - !C == a + ~b + C
  assign sub_op = op == OP_SUB || op == OP_SBCS || op == OP_CMP;
  assign cin = (op == OP_ADCS || op == OP_SBCS) ? flags[1] : sub_op;
  assign bb = sub_op ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, cin};
  assign add_v = ~(a[DATA_W-1] ^ bb[DATA_W-1]) & (sum[DATA_W-1] ^ a[DATA_W-1]);
  assign sh_c = sh == '0 ? flags[1] : op == OP_LSLS ? a[SH_W'(0) - sh] : a[sh - SH_W'(1)];
  always_comb begin
    alu_r = a;
    alu_c = sh_c;
    upd_c = 1'b0;
    upd_v = 1'b0;
    case (op)
      OP_AND: alu_r = a & b;
      OP_ORR: alu_r = a | b;
      OP_EOR: alu_r = a ^ b;
      OP_MVN: alu_r = ~a;
      OP_ADDS, OP_ADCS, OP_SUB, OP_SBCS, OP_CMP: begin
        alu_r = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OP_LSRS: begin alu_r = a >> sh; upd_c = 1'b1; end
      OP_LSLS: begin alu_r = a << sh; upd_c = 1'b1; end
      OP_ASR: begin alu_r = $signed(a) >>> sh; upd_c = 1'b1; end
      OP_ROR: begin alu_r = (a >> sh) | (a << (SH_W'(0) - sh)); upd_c = 1'b1; end
      OP_UXTB: alu_r = {{(DATA_W-8){1'b0}}, a[7:0]};
      OP_UXTH: alu_r = {{(DATA_W-16){1'b0}}, a[15:0]};
      OP_SXTB: alu_r = {{(DATA_W-8){a[7]}}, a[7:0]};
      OP_SXTH: alu_r = {{(DATA_W-16){a[15]}}, a[15:0]};
`ifdef CPU_MUL_EN
      OP_MULS: alu_r = a * b;
`endif
      default: ;
    endcase
  end
  assign nf = {alu_r[DATA_W-1], alu_r == '0, upd_c ? alu_c : flags[1], upd_v ? add_v : flags[0]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc <= '0;
      flags <= '0;
      illegal <= 1'b0;
      ir <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      maddr <= '0;
      wb_we <= 1'b0;
      for (int i = 0; i < 2**RA; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_ack) begin ir <= bus.imem_rdata; state <= S_DECODE; end
        S_DECODE: begin a <= rf[rs1]; b <= rf[rs2]; state <= S_EXEC; end
        S_EXEC: begin
          state <= S_WB;
          res <= alu_r;
          wb_we <= alu_op || op == OP_MOV;
          if (alu_op || op == OP_CMP) flags <= nf;
          if (op == OP_LOADI || op == OP_STORE) begin
            maddr <= PC_W'(a + imm_d);
            wb_we <= op == OP_LOADI;
            state <= S_MEM;
          end
          if (op == OP_J || op == OP_BEQ) begin
            pc <= (op == OP_J || a == b) ? tgt : pc + PC_W'(1);
            state <= S_FETCH;
          end
          if (op == OP_HLT) state <= S_HALT;
          if (!legal) begin illegal <= 1'b1; state <= S_HALT; end
        end
        S_MEM: if (bus.dmem_ack) begin res <= bus.dmem_rdata; state <= S_WB; end
        S_WB: begin
          if (wb_we) rf[rd] <= res;
          pc <= pc + PC_W'(1);
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end
  // Gating with rst drops the fetch request the instant reset asserts
  assign bus.imem_req = rst && state == S_FETCH;
  assign bus.imem_addr = pc;
  assign bus.dmem_req = rst && state == S_MEM;
  assign bus.dmem_we = rst && state == S_MEM && op == OP_STORE;
  assign bus.dmem_addr = maddr;
  assign bus.dmem_wdata = b;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: table-driven ALU vectors plus hand-written memory, branch and reset sequences;
// stores are checked against a scoreboard of expected {addr, data}.
module tb_cpu_core_mc;
  localparam int DW = 32, RA = 4, PW = 16, IW = 40;
  localparam logic [4:0] OP_AND = 5'd1, OP_ORR = 5'd2, OP_EOR = 5'd3, OP_MVN = 5'd4,
                         OP_ADDS = 5'd5, OP_ADCS = 5'd6, OP_SUB = 5'd7, OP_SBCS = 5'd8,
                         OP_MULS = 5'd9, OP_LSRS = 5'd10, OP_LSLS = 5'd11, OP_ASR = 5'd12,
                         OP_ROR = 5'd13, OP_UXTB = 5'd14, OP_UXTH = 5'd15, OP_SXTB = 5'd16,
                         OP_SXTH = 5'd17, OP_CMP = 5'd18, OP_NOP = 5'd19, OP_LOADI = 5'd20,
                         OP_STORE = 5'd21, OP_MOV = 5'd22, OP_J = 5'd23, OP_BEQ = 5'd24,
                         OP_HLT = 5'd25;
  typedef struct {
    logic [4:0] op;
    logic pre;
    logic [DW-1:0] a, b, r;
    logic [3:0] f;
    logic ill;
  } vec_t;
  typedef struct {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } st_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [PW-1:0] pc;
  logic [3:0] flags;
  logic halted, illegal;
  logic [IW-1:0] imem [0:65535];
  logic [DW-1:0] dmem [0:255];
  logic [DW-1:0] pre_a = '0, pre_b = '0;
  logic iack_en = 1'b1;
  int dwait = 0, dcnt = 0, st15 = 0;
  int checks = 0, failures = 0;
  st_t sq [$];
  st_t e;
  vec_t v [$];
  always #5 clk = ~clk;
  cpu_core_mc_if #(.DATA_W(DW), .PC_W(PW), .INSTR_W(IW)) bus ();
  cpu_core_mc #(.DATA_W(DW), .REG_ADDR_W(RA), .PC_W(PW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .flags(flags), .halted(halted), .illegal(illegal)
  );
  assign bus.imem_ack = bus.imem_req && iack_en;
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_ack = bus.dmem_req && dcnt == dwait;
  assign bus.dmem_rdata = bus.dmem_addr == 16'd1 ? pre_a :
                          bus.dmem_addr == 16'd2 ? pre_b : dmem[bus.dmem_addr[7:0]];
  always @(posedge clk) dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && bus.dmem_req && bus.dmem_we) begin
      if (bus.dmem_addr == 16'd15 && bus.dmem_wdata == 32'hAB) st15 <= st15 + 1;
      if (bus.dmem_ack) begin
        dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL store_unexpected got addr=%0h data=%0h exp none", bus.dmem_addr, bus.dmem_wdata);
        end else begin
          e = sq.pop_front();
          check("store_addr", DW'(bus.dmem_addr), DW'(e.addr));
          check("store_data", bus.dmem_wdata, e.data);
        end
      end
    end
  end
  function automatic logic [IW-1:0] enc(logic [4:0] op, int rd, int rs1, int rs2, int imm);
    logic [IW-1:0] w;
    w = '0;
    w[4:0] = op;
    w[5 +: RA] = RA'(rd);
    w[5+RA +: RA] = RA'(rs1);
    w[5+2*RA +: RA] = RA'(rs2);
    w[IW-1:5+3*RA] = (IW-5-3*RA)'(imm);
    return w;
  endfunction
  function automatic vec_t mk(logic [4:0] op, logic pre, logic [DW-1:0] a, logic [DW-1:0] b,
                              logic [DW-1:0] r, logic [3:0] f, logic ill);
    vec_t t;
    t.op = op; t.pre = pre; t.a = a; t.b = b; t.r = r; t.f = f; t.ill = ill;
    return t;
  endfunction
  task automatic do_reset();
    rst = 1'b0;
    iack_en = 1'b1;
    dwait = 0;
    sq.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) imem[i] = enc(OP_HLT, 0, 0, 0, 0);
    imem[65535] = enc(OP_HLT, 0, 0, 0, 0);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic wait_halt(string name);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, DW'(halted), 32'd1);
  endtask
  task automatic wait_pc(logic [PW-1:0] target, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pc != target && n < 300);
    check("reach_pc", DW'(pc), DW'(target));
  endtask
  initial begin
    int n, s0, reqs;
    v.push_back(mk(OP_ADDS, 0, 32'd5, 32'd7, 32'd12, 4'b0000, 0));
    v.push_back(mk(OP_SUB, 0, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000, 0));
    v.push_back(mk(OP_CMP, 0, 32'd5, 32'd5, 32'd0, 4'b0110, 0));
    v.push_back(mk(OP_ADDS, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0110, 0));
    v.push_back(mk(OP_ADDS, 0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001, 0));
    v.push_back(mk(OP_ADCS, 1, 32'd1, 32'd2, 32'd4, 4'b0000, 0));
    v.push_back(mk(OP_SBCS, 0, 32'd5, 32'd3, 32'd1, 4'b0010, 0));
    v.push_back(mk(OP_AND, 0, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 4'b0000, 0));
    v.push_back(mk(OP_EOR, 1, 32'hFFFF0000, 32'hFFFF0000, 32'd0, 4'b0110, 0));
    v.push_back(mk(OP_MVN, 0, 32'd0, 32'd9, 32'hFFFFFFFF, 4'b1000, 0));
    v.push_back(mk(OP_ORR, 0, 32'd1, 32'h80000000, 32'h80000001, 4'b1000, 0));
    v.push_back(mk(OP_LSRS, 0, 32'd3, 32'd1, 32'd1, 4'b0010, 0));
    v.push_back(mk(OP_LSLS, 0, 32'h80000001, 32'd1, 32'd2, 4'b0010, 0));
    v.push_back(mk(OP_ASR, 0, 32'h80000000, 32'd4, 32'hF8000000, 4'b1000, 0));
    v.push_back(mk(OP_ROR, 0, 32'd1, 32'd1, 32'h80000000, 4'b1010, 0));
    v.push_back(mk(OP_LSRS, 1, 32'd3, 32'd0, 32'd3, 4'b0010, 0));
    v.push_back(mk(OP_UXTB, 0, 32'h123456F0, 32'd0, 32'h000000F0, 4'b0000, 0));
    v.push_back(mk(OP_SXTB, 0, 32'h12345680, 32'd0, 32'hFFFFFF80, 4'b1000, 0));
    v.push_back(mk(OP_UXTH, 0, 32'hABCD8765, 32'd0, 32'h00008765, 4'b0000, 0));
    v.push_back(mk(OP_SXTH, 0, 32'h00008000, 32'd0, 32'hFFFF8000, 4'b1000, 0));
    v.push_back(mk(OP_MOV, 1, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 4'b0110, 0));
    v.push_back(mk(OP_NOP, 0, 32'd77, 32'd88, 32'd0, 4'b0000, 0));
`ifdef CPU_MUL_EN
    v.push_back(mk(OP_MULS, 0, 32'd6, 32'd7, 32'd42, 4'b0000, 0));
`else
    v.push_back(mk(OP_MULS, 0, 32'd6, 32'd7, 32'd0, 4'b0000, 1));
`endif
    do_reset();
    check("rst_pc", DW'(pc), 32'd0);
    check("rst_flags", DW'(flags), 32'd0);
    check("rst_halted", DW'(halted), 32'd0);
    check("rst_illegal", DW'(illegal), 32'd0);
    check("rst_imem_req", DW'(bus.imem_req), 32'd0);
    check("rst_dmem_req", DW'(bus.dmem_req), 32'd0);
    check("rst_dmem_we", DW'(bus.dmem_we), 32'd0);
    foreach (v[i]) begin
      do_reset();
      pre_a = v[i].a;
      pre_b = v[i].b;
      imem[0] = enc(OP_LOADI, 2, 0, 0, 1);
      imem[1] = enc(OP_LOADI, 3, 0, 0, 2);
      imem[2] = v[i].pre ? enc(OP_CMP, 0, 0, 0, 0) : enc(OP_NOP, 0, 0, 0, 0);
      imem[3] = enc(v[i].op, 1, 2, 3, 0);
      imem[4] = enc(OP_STORE, 0, 0, 1, 100);
      imem[5] = enc(OP_HLT, 0, 0, 0, 0);
      if (!v[i].ill) sq.push_back('{16'd100, v[i].r});
      release_rst();
      wait_halt("vec_halt");
      check("vec_flags", DW'(flags), DW'(v[i].f));
      check("vec_illegal", DW'(illegal), DW'(v[i].ill));
      check("vec_pc", DW'(pc), v[i].ill ? 32'd3 : 32'd5);
      check("vec_sb_empty", DW'(sq.size()), 32'd0);
    end
    // Latency: LOADI 5, ADDS 4, J 3 cycles with zero-wait acks
    do_reset();
    pre_a = 32'd5;
    pre_b = 32'd7;
    imem[0] = enc(OP_LOADI, 2, 0, 0, 1);
    imem[1] = enc(OP_LOADI, 3, 0, 0, 2);
    imem[2] = enc(OP_ADDS, 1, 2, 3, 0);
    imem[3] = enc(OP_J, 0, 0, 0, 10);
    imem[10] = enc(OP_STORE, 0, 0, 1, 100);
    imem[11] = enc(OP_HLT, 0, 0, 0, 0);
    sq.push_back('{16'd100, 32'd12});
    release_rst();
    wait_pc(1, n);
    check("lat_loadi", n, 32'd5);
    wait_pc(2, n);
    wait_pc(3, n);
    check("lat_adds", n, 32'd4);
    check("adds_flags", DW'(flags), 32'd0);
    wait_pc(10, n);
    check("lat_j", n, 32'd3);
    wait_halt("lat_halt");
    check("lat_sb_empty", DW'(sq.size()), 32'd0);
    // Store with 3 wait states, then load it back
    do_reset();
    dwait = 3;
    pre_a = 32'd12;
    pre_b = 32'hAB;
    imem[0] = enc(OP_LOADI, 1, 0, 0, 1);
    imem[1] = enc(OP_LOADI, 4, 0, 0, 2);
    imem[2] = enc(OP_STORE, 0, 1, 4, 3);
    imem[3] = enc(OP_LOADI, 5, 1, 0, 3);
    imem[4] = enc(OP_STORE, 0, 0, 5, 100);
    sq.push_back('{16'd15, 32'hAB});
    sq.push_back('{16'd100, 32'hAB});
    s0 = st15;
    release_rst();
    wait_halt("mem_halt");
    check("store_hold_cycles", st15 - s0, 32'd4);
    check("mem_sb_empty", DW'(sq.size()), 32'd0);
    check("mem_pc", DW'(pc), 32'd5);
    // Branches and PC wrap
    do_reset();
    pre_a = 32'd5;
    imem[0] = enc(OP_LOADI, 2, 0, 0, 1);
    imem[1] = enc(OP_BEQ, 0, 0, 1, 40);
    imem[40] = enc(OP_BEQ, 0, 0, 2, 80);
    imem[41] = enc(OP_J, 0, 0, 0, 16'hFFFF);
    imem[65535] = enc(OP_NOP, 0, 0, 0, 0);
    release_rst();
    wait_pc(1, n);
    wait_pc(40, n);
    check("lat_beq", n, 32'd3);
    check("beq_taken_addr", DW'(bus.imem_addr), 32'd40);
    check("beq_taken_req", DW'(bus.imem_req), 32'd1);
    wait_pc(41, n);
    check("beq_not_taken_lat", n, 32'd3);
    wait_pc(16'hFFFF, n);
    wait_pc(0, n);
    check("wrap_lat", n, 32'd4);
    check("wrap_addr", DW'(bus.imem_addr), 32'd0);
    // Reserved opcode 0 and HLT
    do_reset();
    imem[0] = '0;
    release_rst();
    wait_halt("ill_halt");
    check("ill_illegal", DW'(illegal), 32'd1);
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
    end
    check("ill_no_req", reqs, 32'd0);
    check("ill_still_halted", DW'(halted), 32'd1);
    do_reset();
    release_rst();
    wait_halt("hlt_halt");
    check("hlt_illegal", DW'(illegal), 32'd0);
    // Asynchronous reset while a fetch is outstanding
    do_reset();
    imem[0] = enc(OP_NOP, 0, 0, 0, 0);
    release_rst();
    wait_pc(1, n);
    iack_en = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_req", DW'(bus.imem_req), 32'd1);
    check("stall_addr", DW'(bus.imem_addr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_req_drop", DW'(bus.imem_req), 32'd0);
    check("async_pc", DW'(pc), 32'd0);
    iack_en = 1'b1;
    repeat (2) @(negedge clk);
    check("async_held_req", DW'(bus.imem_req), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-file CPU.
- Fetches instructions over a req/ack instruction-memory port and decodes the team's 5-bit opcode set (1–25).
- Executes through an internal ALU and register file, and accesses data RAM over a req/ack data port.
- A top-level FSM sequences FETCH, DECODE, EXEC, MEM, WB and HALT, replacing the single always-block pipeline.

Parameters:
- DATA_W, 32: register/ALU/data-bus width (≥16).
- REG_ADDR_W, 4: register index width (2^REG_ADDR_W registers).
- PC_W, 16: PC and memory address width.
- INSTR_W, 32: instruction width; must satisfy INSTR_W ≥ 5+3*REG_ADDR_W+4.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- imem_req out 1: instruction fetch request.
- imem_addr out PC_W: fetch address (= pc).
- imem_ack in 1: fetch complete, imem_rdata valid this cycle.
- imem_rdata in INSTR_W: instruction word.
- dmem_req out 1: data access request.
- dmem_we out 1: 1 = store, 0 = load.
- dmem_addr out PC_W: data address.
- dmem_wdata out DATA_W: store data.
- dmem_ack in 1: access complete; dmem_rdata valid for loads.
- dmem_rdata in DATA_W: load data.
- pc out PC_W: current PC.
- flags out 4: {N,Z,C,V}.
- halted out 1: core in HALT state.
- illegal out 1: sticky; set when halted on a reserved opcode.

Behaviour:
- Fields:
  - opcode = instr[4:0]
  - rd = instr[5 +: RA]
  - rs1 = instr[5+RA +: RA]
  - rs2 = instr[5+2RA +: RA]
  - imm = instr[INSTR_W-1 : 5+3RA], zero-extended
- Reset (rst=0, async): state=FETCH; pc, flags, illegal, halted = 0; all registers = 0; imem_req, dmem_req, dmem_we = 0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Hold both stable until imem_ack=1 is sampled.
  - On ack, latch instruction and go to DECODE; ack in the same cycle as req is legal.
- DECODE: read rs1/rs2 operands into latches → EXEC.
- EXEC:
  - Opcodes 1–17 (ALU): compute result and flags → WB.
  - CMP (18): flags from rs1-rs2; no register write → WB.
  - NOP (19) → WB with no effects.
  - LOADI (20), STORE (21): address = (rs1+imm) truncated to PC_W → MEM.
  - MOV (22): result = rs1 → WB; flags unchanged.
  - J (23): pc = imm[PC_W-1:0] → FETCH.
  - BEQ (24): pc = imm if rs1==rs2, else pc+1 → FETCH.
  - HLT (25) → HALT.
  - 0, 26–31 → HALT with illegal=1.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE with dmem_wdata=rs2.
  - Hold until dmem_ack. On ack: LOADI latches dmem_rdata → WB; STORE → WB.
- WB: write rd if the op produces a result, pc = pc+1 (wraps mod 2^PC_W) → FETCH.
- HALT: absorbing; only reset exits. halted=1; no requests.
- ALU semantics (results truncated to DATA_W):
  - AND/ORR/EOR/MVN: logic ops; MVN = ~rs1.
  - ADDS = rs1+rs2; ADCS adds C.
  - SUB = rs1-rs2; SBCS = rs1-rs2-!C.
  - Shift amount = rs2[log2(DATA_W)-1:0]: LSRS, LSLS, ASR, ROR.
  - UXTB/UXTH/SXTB/SXTH extend rs1[7:0] or rs1[15:0].
- Flag rules:
  - N = result MSB; Z = result==0.
  - Add: C = carry out. Subtract: C = no-borrow. Both set V = signed overflow.
  - Logic and extend ops: C, V unchanged.
  - Shifts/rotate: C = last bit shifted out; shift amount 0 leaves C unchanged; V unchanged.
- Latency:
  - ALU/MOV/CMP/NOP: 4 cycles with zero-wait ack.
  - J/BEQ: 3 cycles.
  - LOADI/STORE: 5 cycles plus wait states.
- rd == rs1: the operand is already latched, so the write is safe.
- Reset asserted mid-request drops req immediately; any late ack is ignored.

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: MULS (9) writes the low DATA_W bits of rs1*rs2; N and Z updated, C and V unchanged.
- Undefined: no multiplier is synthesised; MULS is treated as a reserved opcode (HALT, illegal=1).

Test Plan:
- Reset, then imem returns ADDS r1=r2+r3 with r2=5, r3=7, zero-wait → r1=12, flags=0000, pc=1 after 4 cycles.
- SUB 3-5, DATA_W=32 → result 0xFFFFFFFE, N=1, Z=0, C=0, V=0; CMP 5,5 → Z=1, C=1, no register write.
- STORE r4 to addr r1+3 (r1=12, r4=0xAB), dmem_ack delayed 3 cycles → req/addr=15/data held stable 4 cycles; then LOADI from 15 → rd=0xAB.
- BEQ taken (r1==r2) to imm=40 → next imem_addr=40; not taken → 41 from pc=40; J to 0xFFFF, then WB → pc wraps to 0.
- Opcode 0 → halted=1, illegal=1, no further imem_req; HLT → halted=1, illegal=0; rst low mid-FETCH → imem_req falls asynchronously, pc=0.
- MULS 6*7: with CPU_MUL_EN → 42; without → illegal=1.
